instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side counterpart of the fetch-stage instruction memory: fills it at boot, while the fetch stage only reads it.
- Accepts a little-endian byte stream (typically from a UART receiver) and packs the bytes into 32-bit instruction words.
- Drives a synchronous word-write port into instruction memory, starting at word 0.
- Holds the core in reset until the whole program is written, then releases it.

Parameters:
- ADDRESS_WIDTH, 32, width of wr_addr (byte address).
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word).
- MEM_SIZE, 512, instruction memory depth in words; larger word counts are rejected.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_byte  input  8  stream data byte.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  loader can accept a byte this cycle.
- load_start  input  1  one-cycle pulse; restarts loading from DONE or ERR.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  ADDRESS_WIDTH  byte address of the write, word-aligned (bits [1:0] = 0).
- wr_data  output  DATA_WIDTH  instruction word to write.
- core_hold  output  1  high keeps the core in reset.
- done  output  1  program fully written.
- error  output  1  load aborted.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state=LEN0, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, core_hold=1. Byte, word and checksum counters clear to 0.
- Handshake: a byte is accepted when in_valid && in_ready at a rising edge.
  - in_ready is combinational, equal to (state is LEN0, LEN1, DATA or CSUM) && !rst.
  - in_ready is low in DONE and ERR.
- Stream format: count[7:0], count[15:8], then count×4 data bytes, each word least-significant byte first.
- State LEN0: on accept, latch count[7:0]; go to LEN1.
- State LEN1: on accept, latch count[15:8], then:
  - full count > MEM_SIZE → ERR.
  - full count == 0 → DONE (no writes).
  - otherwise → DATA.
- State DATA: on each accept, place the byte into lane byte_idx (0..3) of the assembly register; byte_idx increments and wraps 3→0.
  - On accepting lane 3: the next cycle has wr_en=1, wr_data = the full assembled word, wr_addr = word_idx<<2. word_idx then increments.
  - wr_en is high for exactly that one cycle; wr_addr and wr_data hold their last values afterward.
  - After the last word is accepted (word_idx+1 == count): go to CSUM if the checksum feature is enabled, else to DONE.
  - The DONE transition is timed so that done rises the cycle after the final wr_en, never in the same cycle.
- State DONE: done=1, core_hold=0, error=0.
- State ERR: error=1, core_hold=1, done=0. No further writes.
- load_start, in DONE or ERR only:
  - → LEN0; clears done, error and all counters.
  - core_hold returns to 1 in the same cycle that done drops.
  - Ignored in any other state.
- rst in any state, including mid-word: return to reset values. A partially assembled word is discarded and never written.
- Bytes presented while in_ready=0 are not consumed. The loader produces no backpressure stalls in accepting states.
- The write port supports a full-rate stream: up to one byte per cycle, one word write every 4 accepted bytes.

Optional Feature:
- Macro: INSTR_LOADER_CHECKSUM_EN.
- When defined:
  - An 8-bit XOR accumulator covers every data byte; it is cleared in LEN0 and does not include the count bytes.
  - After the last data byte, state CSUM accepts one extra byte.
  - If that byte equals the accumulator → DONE; otherwise → ERR.
  - Words already written are not rolled back.
- When undefined: no CSUM state and no accumulator; the last data byte leads directly to DONE.

Test Plan:
- After reset, stream 02 00 13 00 00 00 93 00 10 00 → wr_en pulses twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. done=1 and core_hold=0 exactly one cycle after the second wr_en.
- Count 00 00 → no wr_en; DONE one cycle after the LEN1 accept; in_ready=0 thereafter.
- Count 01 02 (513 > 512) → ERR, error=1, core_hold=1, no writes. Then a load_start pulse → LEN0, error=0, in_ready=1.
- Stall test: the same 2-word stream with in_valid toggling every other cycle → identical writes and data; wr_en never high more than one cycle per word.
- rst asserted after 2 data bytes of word 0 → no wr_en. The restart stream 01 00 EF BE AD DE writes 0xDEADBEEF to addr 0x0.
- With INSTR_LOADER_CHECKSUM_EN: a 1-word stream of 13 00 00 00 followed by checksum 13 → DONE. The same stream with checksum 00 → ERR, although the write to addr 0x0 still occurred.

Source files
------------

// File: rtl/instr_mem_loader_if.sv
// ============================================================================
//  Module      : instr_mem_loader_if
//  Description : Byte-stream input and instruction-memory write port used by
//                instr_mem_loader.
//                  in_byte  / in_valid / in_ready : byte stream, accepted on
//                                                   in_valid && in_ready
//                  wr_en / wr_addr / wr_data       : one-cycle word write into
//                                                   instruction memory
//                Modports:
//                  slave  - the loader (consumes the stream, drives the write)
//                  master - the environment (byte source, memory sink)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_mem_loader_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);

  logic [7:0]               in_byte;
  logic                     in_valid;
  logic                     in_ready;
  logic                     wr_en;
  logic [ADDRESS_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0]    wr_data;

  modport slave (
    input  in_byte,
    input  in_valid,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport master (
    output in_byte,
    output in_valid,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

`default_nettype wire

// File: rtl/instr_mem_loader.sv
// ============================================================================
//  Module      : instr_mem_loader
//  Description : Boot loader for the instruction memory. Receives a
//                little-endian byte stream
//                  count[7:0], count[15:8], count x 4 data bytes (LSB first)
//                packs every 4 bytes into a 32-bit word and writes it to
//                consecutive word addresses starting at 0. The core is held
//                in reset (core_hold) until the whole program is written.
//
//  Ports       : clk        - system clock, rising-edge
//                rst        - synchronous, active-high reset
//                bus        - instr_mem_loader_if.slave
//                             (in_byte/in_valid/in_ready stream,
//                              wr_en/wr_addr/wr_data memory write port)
//                load_start - one-cycle pulse, restarts from DONE or ERR
//                core_hold  - high keeps the core in reset
//                done       - program fully written
//                error      - load aborted
//
//  Parameters  : ADDRESS_WIDTH - width of wr_addr (byte address)
//                DATA_WIDTH    - instruction word width, must be 32
//                MEM_SIZE      - memory depth in words; larger counts -> ERR
//
//  Options     : INSTR_LOADER_CHECKSUM_EN - when defined, a trailing XOR
//                checksum byte over all data bytes is checked before DONE.
//
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_mem_loader #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int MEM_SIZE      = 512
) (
  input  wire logic           clk,
  input  wire logic           rst,
  instr_mem_loader_if.slave   bus,
  input  wire logic           load_start,
  output logic                core_hold,
  output logic                done,
  output logic                error
);

`ifdef INSTR_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_CSUM = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
`else
  typedef enum logic [2:0] {
    S_LEN0 = 3'd0,
    S_LEN1 = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;
`endif

  state_t r_state;
  state_t w_state_nxt;

  logic [15:0]              r_count;     // word count from the header
  logic [15:0]              r_word_idx;  // words written so far
  logic [1:0]               r_byte_idx;  // next lane to fill
  logic [23:0]              r_asm;       // lanes 0..2; lane 3 goes straight to wr_data
  logic                     r_wr_en;
  logic [ADDRESS_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]               r_csum;
`endif

  logic        w_accepting;
  logic        w_in_ready;
  logic        w_accept;
  logic [15:0] w_count_full;
  logic        w_last_word;

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
`ifdef INSTR_LOADER_CHECKSUM_EN
  assign w_accepting = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA) || (r_state == S_CSUM);
`else
  assign w_accepting = (r_state == S_LEN0) || (r_state == S_LEN1) ||
                       (r_state == S_DATA);
`endif

  assign w_in_ready = w_accepting && !rst;
  assign w_accept   = bus.in_valid && w_in_ready;

  // Full count as it will be once the high byte in LEN1 is latched.
  assign w_count_full = {bus.in_byte, r_count[7:0]};
  assign w_last_word  = ((r_word_idx + 16'd1) == r_count);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_LEN0;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LEN0: begin
        if (w_accept) begin
          w_state_nxt = S_LEN1;
        end
      end
      S_LEN1: begin
        if (w_accept) begin
          if (32'(w_count_full) > MEM_SIZE) begin
            w_state_nxt = S_ERR;
          end else if (w_count_full == 16'd0) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        // The final word's write strobe fires in the first cycle of the
        // following state; done is masked during that cycle (see below).
        if (w_accept && (r_byte_idx == 2'd3) && w_last_word) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          w_state_nxt = S_CSUM;
`else
          w_state_nxt = S_DONE;
`endif
        end
      end
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: begin
        if (w_accept) begin
          w_state_nxt = (bus.in_byte == r_csum) ? S_DONE : S_ERR;
        end
      end
`endif
      S_DONE, S_ERR: begin
        if (load_start) begin
          w_state_nxt = S_LEN0;
        end
      end
      default: begin
        w_state_nxt = S_LEN0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: header latch, word assembly, write port, checksum
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= 16'd0;
      r_word_idx <= 16'd0;
      r_byte_idx <= 2'd0;
      r_asm      <= 24'd0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      r_csum     <= 8'd0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      case (r_state)
        S_LEN0: begin
`ifdef INSTR_LOADER_CHECKSUM_EN
          r_csum <= 8'd0;
`endif
          if (w_accept) begin
            r_count[7:0] <= bus.in_byte;
          end
        end
        S_LEN1: begin
          if (w_accept) begin
            r_count[15:8] <= bus.in_byte;
          end
        end
        S_DATA: begin
          if (w_accept) begin
            r_byte_idx <= r_byte_idx + 2'd1;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum     <= r_csum ^ bus.in_byte;
`endif
            case (r_byte_idx)
              2'd0: r_asm[7:0]   <= bus.in_byte;
              2'd1: r_asm[15:8]  <= bus.in_byte;
              2'd2: r_asm[23:16] <= bus.in_byte;
              default: begin
                r_wr_en    <= 1'b1;
                r_wr_data  <= {bus.in_byte, r_asm};
                r_wr_addr  <= ADDRESS_WIDTH'({r_word_idx, 2'b00});
                r_word_idx <= r_word_idx + 16'd1;
              end
            endcase
          end
        end
        S_DONE, S_ERR: begin
          // Restart: counters clear, the last write address/data stay visible.
          if (load_start) begin
            r_count    <= 16'd0;
            r_word_idx <= 16'd0;
            r_byte_idx <= 2'd0;
            r_asm      <= 24'd0;
`ifdef INSTR_LOADER_CHECKSUM_EN
            r_csum     <= 8'd0;
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_addr  = r_wr_addr;
  assign bus.wr_data  = r_wr_data;

  // Masking with r_wr_en keeps done low during the final write strobe so the
  // core is never released while the last word is still being written.
  assign done      = (r_state == S_DONE) && !r_wr_en;
  assign error     = (r_state == S_ERR);
  assign core_hold = !done;

endmodule

`default_nettype wire

// File: tb/tb_instr_mem_loader.sv
// ============================================================================
//  Module      : tb_instr_mem_loader
//  Description : Self-checking bench for instr_mem_loader. A table of per-cycle
//                {inputs, expected outputs} records is applied one row per
//                clock, followed by hand-written sequences for the 512-word
//                boundary, ignored load_start and the checksum option.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_mem_loader;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  localparam logic [31:0] D0 = 32'h0000_0013;
  localparam logic [31:0] D1 = 32'h0010_0093;
  localparam logic [31:0] DB = 32'hDEAD_BEEF;
  localparam logic [7:0]  C1 = 8'h90;   // 13^00^00^00^93^00^10^00
  localparam logic [7:0]  C2 = 8'h22;   // EF^BE^AD^DE

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load_start = 1'b0;
  logic core_hold;
  logic done;
  logic error;

  int n_checks = 0;
  int n_fail   = 0;

  instr_mem_loader_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  instr_mem_loader #(
    .ADDRESS_WIDTH(32),
    .DATA_WIDTH   (32),
    .MEM_SIZE     (512)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .load_start(load_start),
    .core_hold (core_hold),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rst;
    bit          ls;
    bit          val;
    logic [7:0]  byt;
    bit          e_ready;
    bit          e_wr_en;
    logic [31:0] e_addr;
    logic [31:0] e_data;
    bit          e_done;
    bit          e_error;
    bit          e_hold;
  } vec_t;

  vec_t rows[$];

  task automatic v(input bit r, input bit ls, input bit val, input logic [7:0] b,
                   input bit rdy, input bit we, input logic [31:0] a,
                   input logic [31:0] d, input bit dn, input bit er, input bit h);
    vec_t x;
    x.rst = r; x.ls = ls; x.val = val; x.byt = b;
    x.e_ready = rdy; x.e_wr_en = we; x.e_addr = a; x.e_data = d;
    x.e_done = dn; x.e_error = er; x.e_hold = h;
    rows.push_back(x);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then let them settle.
  task automatic drive(input bit r, input bit ls, input bit val, input logic [7:0] b);
    @(negedge clk);
    rst          = r;
    load_start   = ls;
    bus.in_valid = val;
    bus.in_byte  = b;
    #1;
  endtask

  task automatic chk_all(input string tag, input int idx, input bit rdy, input bit we,
                         input logic [31:0] a, input logic [31:0] d,
                         input bit dn, input bit er, input bit h);
    chk({tag, ".in_ready"},  idx, 32'(bus.in_ready), 32'(rdy));
    chk({tag, ".wr_en"},     idx, 32'(bus.wr_en),    32'(we));
    chk({tag, ".wr_addr"},   idx, bus.wr_addr,       a);
    chk({tag, ".wr_data"},   idx, bus.wr_data,       d);
    chk({tag, ".done"},      idx, 32'(done),         32'(dn));
    chk({tag, ".error"},     idx, 32'(error),        32'(er));
    chk({tag, ".core_hold"}, idx, 32'(core_hold),    32'(h));
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_byte  = 8'h00;

    // ---------------- table ----------------
    //   rst ls val byte   rdy we addr data done err hold
    v(1,0,0,8'h00, 0,0,32'h0,32'h0,0,0,1);            // reset
    // 2-word program at full rate
    v(0,0,1,8'h02, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'h13, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'h93, 1,1,32'h0,D0,0,0,1);               // word 0 write
    v(0,0,1,8'h00, 1,0,32'h0,D0,0,0,1);
    v(0,0,1,8'h10, 1,0,32'h0,D0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,D0,0,0,1);
    v(0,0,CS,C1,   CS,1,32'h4,D1,0,0,1);              // word 1 write, done still low
    v(0,0,0,8'h00, 0,0,32'h4,D1,1,0,0);               // done, core released
    v(0,1,0,8'h00, 0,0,32'h4,D1,1,0,0);               // restart pulse
    // zero-word program
    v(0,0,1,8'h00, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h55, 0,0,32'h4,D1,1,0,0);               // DONE, byte not consumed
    v(0,1,0,8'h00, 0,0,32'h4,D1,1,0,0);
    // count 513 -> ERR
    v(0,0,1,8'h01, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h02, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'hAA, 0,0,32'h4,D1,0,1,1);
    v(0,1,0,8'h00, 0,0,32'h4,D1,0,1,1);
    // same 2-word program, in_valid every other cycle
    v(0,0,0,8'hEE, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h02, 1,0,32'h4,D1,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h4,D1,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h13, 1,0,32'h4,D1,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h4,D1,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h4,D1,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h4,D1,0,0,1);
    v(0,0,0,8'hEE, 1,1,32'h0,D0,0,0,1);
    v(0,0,1,8'h93, 1,0,32'h0,D0,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h0,D0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,D0,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h0,D0,0,0,1);
    v(0,0,1,8'h10, 1,0,32'h0,D0,0,0,1);
    v(0,0,0,8'hEE, 1,0,32'h0,D0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,D0,0,0,1);
    v(0,0,CS,C1,   CS,1,32'h4,D1,0,0,1);
    v(0,1,0,8'h00, 0,0,32'h4,D1,1,0,0);
    // reset in the middle of word 0, then restart with 0xDEADBEEF
    v(0,0,1,8'h01, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'hAA, 1,0,32'h4,D1,0,0,1);
    v(0,0,1,8'hBB, 1,0,32'h4,D1,0,0,1);
    v(1,0,1,8'hCC, 0,0,32'h4,D1,0,0,1);
    v(0,0,1,8'h01, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'h00, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'hEF, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'hBE, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'hAD, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,1,8'hDE, 1,0,32'h0,32'h0,0,0,1);
    v(0,0,CS,C2,   CS,1,32'h0,DB,0,0,1);
    v(0,0,0,8'h00, 0,0,32'h0,DB,1,0,0);

    for (int i = 0; i < rows.size(); i++) begin
      drive(rows[i].rst, rows[i].ls, rows[i].val, rows[i].byt);
      chk_all("tbl", i, rows[i].e_ready, rows[i].e_wr_en, rows[i].e_addr,
              rows[i].e_data, rows[i].e_done, rows[i].e_error, rows[i].e_hold);
    end

    // ---------------- count 512 accepted, load_start ignored mid-load -------
    drive(0, 1, 0, 8'h00);                    // leave DONE
    drive(0, 0, 1, 8'h00);
    drive(0, 0, 1, 8'h02);                    // count = 512
    chk_all("max", 0, 1, 0, 32'h0, DB, 0, 0, 1);
    drive(0, 0, 1, 8'h11);
    drive(0, 0, 1, 8'h22);
    drive(0, 1, 0, 8'h00);                    // must be ignored in DATA
    chk_all("max", 1, 1, 0, 32'h0, DB, 0, 0, 1);
    drive(0, 0, 1, 8'h33);
    chk_all("max", 2, 1, 0, 32'h0, DB, 0, 0, 1);
    drive(0, 0, 1, 8'h44);
    drive(0, 0, 0, 8'h00);
    chk_all("max", 3, 1, 1, 32'h0, 32'h4433_2211, 0, 0, 1);
    drive(0, 0, 0, 8'h00);
    chk_all("max", 4, 1, 0, 32'h0, 32'h4433_2211, 0, 0, 1);
    drive(1, 0, 0, 8'h00);
    drive(0, 0, 0, 8'h00);
    chk_all("max", 5, 1, 0, 32'h0, 32'h0, 0, 0, 1);

`ifdef INSTR_LOADER_CHECKSUM_EN
    // ---------------- checksum good / bad ------------------------------------
    for (int k = 0; k < 2; k++) begin
      logic [7:0] cs_byte;
      cs_byte = (k == 0) ? 8'h13 : 8'h00;
      drive(0, 0, 1, 8'h01);
      drive(0, 0, 1, 8'h00);
      drive(0, 0, 1, 8'h13);
      drive(0, 0, 1, 8'h00);
      drive(0, 0, 1, 8'h00);
      drive(0, 0, 1, 8'h00);
      drive(0, 0, 1, cs_byte);
      chk_all("csum_wr", k, 1, 1, 32'h0, D0, 0, 0, 1);
      drive(0, 0, 0, 8'h00);
      if (k == 0) chk_all("csum_ok", k, 0, 0, 32'h0, D0, 1, 0, 0);
      else        chk_all("csum_bad", k, 0, 0, 32'h0, D0, 0, 1, 1);
      drive(0, 1, 0, 8'h00);
      drive(0, 0, 0, 8'h00);
      chk_all("csum_rst", k, 1, 0, 32'h0, D0, 0, 0, 1);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
